// File: rtl/move_sched.sv
// move_sched: tick-paced arbiter of button jogs and PicoBlaze moves onto the position counter oper port
module move_sched #(
   parameter int TICK_DIV = 50000,
   parameter int DIV_W    = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       cpu_we,
   input  logic [7:0] cpu_data,
   input  logic       at_min,
   input  logic       at_max,
   output logic [1:0] oper,
   output logic       busy,
   output logic       cpu_ack,
   output logic       lim_hit,
   output logic [2:0] state_o
);
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      MANUAL  = 3'd1,
      STEP    = 3'd2,
      SWEEP_L = 3'd3,
      SWEEP_R = 3'd4
   } state_t;
   state_t state, nxt;
   logic [DIV_W-1:0] div;
   logic [5:0] cnt, cnt_n;
   logic [1:0] op, oper_n;
   logic dir, dir_n, lim_n, ack_n, tick, one, stop;
   assign op      = cpu_data[1:0];
   assign tick    = div == DIV_W'(TICK_DIV - 1);
   assign one     = btn_left ^ btn_right;
   assign stop    = cpu_we && op == 2'b00;
   assign busy    = state == STEP || state == SWEEP_L || state == SWEEP_R;
   assign state_o = state;
   // prescaler restarts on every state change so the first move lands TICK_DIV cycles after entry
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state   <= IDLE;
         div     <= '0;
         cnt     <= '0;
         dir     <= 1'b0;
         oper    <= 2'b00;
         cpu_ack <= 1'b0;
         lim_hit <= 1'b0;
      end else begin
         state   <= nxt;
         div     <= (nxt != state || tick) ? '0 : div + 1'b1;
         cnt     <= cnt_n;
         dir     <= dir_n;
         oper    <= oper_n;
         cpu_ack <= ack_n;
         lim_hit <= lim_n;
      end
   always_comb begin
      nxt    = state;
      cnt_n  = cnt;
      dir_n  = dir;
      oper_n = 2'b00;
      ack_n  = 1'b0;
      lim_n  = lim_hit;
      case (state)
         IDLE:
            if (cpu_we) begin
               ack_n = 1'b1;
               lim_n = 1'b0;
               if (op == 2'b11) nxt = SWEEP_R;
               else if (op != 2'b00 && cpu_data[7:2] != 6'd0) begin
                  nxt   = STEP;
                  dir_n = op[1];
                  cnt_n = cpu_data[7:2];
               end
            end else if (one) nxt = MANUAL;
         MANUAL:
            if (!one) nxt = IDLE;
            else if (tick) oper_n = btn_right ? (at_max ? 2'b00 : 2'b10) : (at_min ? 2'b00 : 2'b01);
         default: begin
            ack_n = cpu_we;
            if (stop) lim_n = 1'b0;
            // buttons and stop pre-empt the tick: no move goes out on the abort cycle
            if (btn_left || btn_right || stop) nxt = IDLE;
            else if (tick)
               case (state)
                  STEP:
                     if (dir ? at_max : at_min) begin
                        nxt   = IDLE;
                        lim_n = 1'b1;
                     end else begin
                        oper_n = dir ? 2'b10 : 2'b01;
                        cnt_n  = cnt - 6'd1;
                        if (cnt == 6'd1) nxt = IDLE;
                     end
                  SWEEP_R:
                     if (!at_max) oper_n = 2'b10;
                     else if (!at_min) nxt = SWEEP_L;
                  SWEEP_L:
                     if (!at_min) oper_n = 2'b01;
                     else if (!at_max) nxt = SWEEP_R;
                  default: nxt = IDLE;
               endcase
         end
      endcase
   end
endmodule

// File: tb/tb_move_sched.sv
// tb_move_sched: randomized and directed checks of move_sched against a cycle-level behavioural model
module tb_move_sched;
   localparam int TD = 4;
   logic clk = 1'b0, reset = 1'b1;
   logic btn_left = 1'b0, btn_right = 1'b0, cpu_we = 1'b0, at_min = 1'b0, at_max = 1'b0;
   logic [7:0] cpu_data = 8'h00;
   logic [1:0] oper;
   logic busy, cpu_ack, lim_hit;
   logic [2:0] state_o;
   int checks = 0, failures = 0;
   int m_mode, m_age, m_cnt, e_oper, n_r, n_l;
   bit m_right, m_lim, e_ack;

   move_sched #(.TICK_DIV(TD), .DIV_W(3)) dut (
      .clk(clk), .reset(reset), .btn_left(btn_left), .btn_right(btn_right),
      .cpu_we(cpu_we), .cpu_data(cpu_data), .at_min(at_min), .at_max(at_max),
      .oper(oper), .busy(busy), .cpu_ack(cpu_ack), .lim_hit(lim_hit), .state_o(state_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_age = 0; m_cnt = 0; m_right = 0; m_lim = 0; e_oper = 0; e_ack = 0;
   endtask

   // modes: 0 idle, 1 manual, 2 step, 3 sweep left, 4 sweep right
   task automatic model();
      bit tick = (m_age % TD) == TD - 1;
      int nm = m_mode, no = 0, op = int'(cpu_data[1:0]), n = int'(cpu_data[7:2]);
      bit na = 0;
      if (m_mode == 0) begin
         if (cpu_we) begin
            na = 1; m_lim = 0;
            if (op == 3) nm = 4;
            else if (op != 0 && n > 0) begin nm = 2; m_cnt = n; m_right = (op == 2); end
         end else if (btn_left != btn_right) nm = 1;
      end else if (m_mode == 1) begin
         if (btn_left == btn_right) nm = 0;
         else if (tick) no = btn_right ? (at_max ? 0 : 2) : (at_min ? 0 : 1);
      end else begin
         na = cpu_we;
         if (cpu_we && op == 0) m_lim = 0;
         if (btn_left || btn_right || (cpu_we && op == 0)) nm = 0;
         else if (tick) begin
            if (m_mode == 2) begin
               if (m_right ? at_max : at_min) begin nm = 0; m_lim = 1; end
               else begin no = m_right ? 2 : 1; m_cnt--; if (m_cnt == 0) nm = 0; end
            end else if (m_mode == 4) begin
               if (!at_max) no = 2; else if (!at_min) nm = 3;
            end else begin
               if (!at_min) no = 1; else if (!at_max) nm = 4;
            end
         end
      end
      m_age = (nm != m_mode) ? 0 : m_age + 1;
      m_mode = nm; e_oper = no; e_ack = na;
   endtask

   task automatic cyc();
      @(posedge clk);
      model();
      #1;
      chk("oper", int'(oper), e_oper);
      chk("busy", int'(busy), int'(m_mode >= 2));
      chk("ack", int'(cpu_ack), int'(e_ack));
      chk("lim", int'(lim_hit), int'(m_lim));
      chk("state", int'(state_o), m_mode);
      if (oper == 2'b10) n_r++;
      if (oper == 2'b01) n_l++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic cmd(input logic [7:0] d);
      cpu_data = d; cpu_we = 1'b1;
      cyc();
      cpu_we = 1'b0;
   endtask

   initial begin
      model_reset();
      #1;
      chk("rst_oper", int'(oper), 0);
      chk("rst_state", int'(state_o), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_ack", int'(cpu_ack), 0);
      chk("rst_lim", int'(lim_hit), 0);
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
      run(3);
      n_r = 0; n_l = 0;
      cmd(8'h0E);
      chk("t1_ack", int'(cpu_ack), 1);
      run(20);
      chk("t1_moves", n_r, 3);
      chk("t1_idle", int'(busy), 0);
      n_l = 0;
      cmd(8'h29);
      for (int i = 0; i < 100 && n_l < 2; i++) cyc();
      at_min = 1'b1;
      run(12);
      chk("t2_moves", n_l, 2);
      chk("t2_lim", int'(lim_hit), 1);
      at_min = 1'b0;
      cmd(8'h06);
      chk("t2_clr", int'(lim_hit), 0);
      run(10);
      n_r = 0; n_l = 0;
      cmd(8'h03);
      for (int i = 0; i < 100 && n_r < 3; i++) cyc();
      at_max = 1'b1;
      for (int i = 0; i < 100 && state_o != 3'd3; i++) cyc();
      at_max = 1'b0;
      for (int i = 0; i < 100 && n_l < 5; i++) cyc();
      at_min = 1'b1;
      for (int i = 0; i < 100 && state_o != 3'd4; i++) cyc();
      at_min = 1'b0;
      run(9);
      chk("t3_r", n_r, 5);
      chk("t3_l", n_l, 5);
      cmd(8'h00);
      chk("t3_stop", int'(state_o), 0);
      n_r = 0;
      btn_right = 1'b1;
      run(20);
      chk("t4_manual", n_r, 4);
      btn_left = 1'b1;
      run(8);
      btn_left = 1'b0; btn_right = 1'b0;
      run(2);
      cmd(8'h03);
      run(10);
      btn_left = 1'b1;
      cyc();
      btn_left = 1'b0;
      chk("t5_abort", int'(state_o), 0);
      btn_right = 1'b1;
      cmd(8'h0A);
      chk("t5_cpu_wins", int'(state_o), 2);
      btn_right = 1'b0;
      run(4);
      cmd(8'h52);
      run(6);
      #3 reset = 1'b1;
      #1;
      chk("t6_oper", int'(oper), 0);
      chk("t6_busy", int'(busy), 0);
      chk("t6_state", int'(state_o), 0);
      model_reset();
      @(posedge clk); #1;
      reset = 1'b0;
      n_r = 0; n_l = 0;
      run(20);
      chk("t6_nomove", n_r + n_l, 0);
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(29) == 0) begin
            btn_left  = $urandom_range(3) == 0;
            btn_right = $urandom_range(3) == 0;
         end
         if ($urandom_range(24) == 0) begin
            at_min = $urandom_range(2) == 0;
            at_max = $urandom_range(2) == 0;
         end
         cpu_we   = $urandom_range(19) == 0;
         cpu_data = 8'($urandom);
         cyc();
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
